dsc_mul_engine: RTL and testbench

- Parametrised N-input deterministic stochastic (unary) multiplier core.
- Uses clock-divided stream generators: stream i advances once per wrap of stream i-1, so a full run is exact.
- Adds a start/finish handshake, a programmable cycle budget for progressive precision, an exact early-exit mode and clock-enable stalling.
- Sits between the binary operand registers and the result/cycle-count collection logic of the arch-sweep datapath.

---
 rtl/dsc_pkg.sv | 22 ++
 rtl/dsc_stream_gen.sv | 35 +++
 rtl/dsc_mul_engine.sv | 139 +++++++++++++
 tb/tb_dsc_mul_engine.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dsc_pkg.sv
// Shared types and helpers for the deterministic stochastic multiplier.
// Default geometry, the FSM state encoding and the exact-length helper.
package dsc_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_INPUTS = 2;
  localparam int OUT_WIDTH      = DEF_NUM_INPUTS * DEF_DATA_WIDTH;
  localparam int LEN_WIDTH      = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } dsc_state_e;

  // Exact run length: once the slowest stream passes its operand it is 0 forever.
  function automatic logic [LEN_WIDTH-1:0] exact_len(input logic [31:0] top_op,
                                                     input int unsigned shift);
    exact_len = {32'd0, top_op} << shift;
  endfunction

endpackage

// File: rtl/dsc_stream_gen.sv
// One clock-divided unary stream: a counter compared against its operand.
// The wrap output advances the next, slower stream in the chain.
module dsc_stream_gen
  import dsc_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  gclk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  adv,
  input  logic [DATA_WIDTH-1:0] op,
  output logic                  wrap,
  output logic                  s_bit
);

  logic [DATA_WIDTH-1:0] ctr_q;

  assign wrap  = adv && (ctr_q == '1);
  assign s_bit = (ctr_q < op);

  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      ctr_q <= '0;
    end else if (en) begin
      if (clr) begin
        ctr_q <= '0;
      end else if (adv) begin
        ctr_q <= ctr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dsc_mul_engine.sv
// N-input deterministic stochastic multiplier: start/finish handshake, cycle
// budget, exact early exit and clock-enable stalling around a stream chain.
module dsc_mul_engine
  import dsc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_INPUTS = 2,
  parameter int CYC_WIDTH  = NUM_INPUTS * DATA_WIDTH + 1
) (
  input  logic                             gclk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             start,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] bin_data_in,
  input  logic [CYC_WIDTH-1:0]             cycle_limit,
  input  logic                             exact_exit_en,
  output logic                             ready,
  output logic                             op_finished,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0] bin_data_out,
  output logic [CYC_WIDTH-1:0]             cycle_count,
  output logic                             truncated,
  output dsc_state_e                       dbg_state
);

  localparam int OUT_W = NUM_INPUTS * DATA_WIDTH;

  // Handshake: a request is accepted on a rising edge where en, start and
  // ready are all high; ready is high in IDLE and DONE, low in RUN.
  dsc_state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] op_q [NUM_INPUTS];
  logic [CYC_WIDTH-1:0]  limit_q;
  logic                  exact_q;
  logic [OUT_W-1:0]      ones_q;
  logic [CYC_WIDTH-1:0]  cyc_q;
  logic [CYC_WIDTH-1:0]  cyc_next;
  logic                  trunc_q;

  logic [NUM_INPUTS-1:0] s_vec;
  logic [NUM_INPUTS-1:0] wrap_vec;
  logic [NUM_INPUTS-1:0] adv_vec;

  logic                  accept;
  logic                  any_zero;
  logic                  zero_fast;
  logic                  running;
  logic                  finish;
  logic [LEN_WIDTH-1:0]  c_ext;
  logic [LEN_WIDTH-1:0]  lim_ext;
  logic [LEN_WIDTH-1:0]  l_len;

  assign ready     = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign accept    = en && start && ready;
  assign running   = en && (state_q == ST_RUN);
  assign zero_fast = exact_exit_en && any_zero;

  always_comb begin
    any_zero = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (bin_data_in[i*DATA_WIDTH +: DATA_WIDTH] == '0) any_zero = 1'b1;
    end
  end

  assign adv_vec[0] = running;
  for (genvar g = 1; g < NUM_INPUTS; g++) begin : g_adv
    assign adv_vec[g] = wrap_vec[g-1];
  end

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_stream
    dsc_stream_gen #(.DATA_WIDTH(DATA_WIDTH)) u_stream (
      .gclk  (gclk),
      .rst   (rst),
      .en    (en),
      .clr   (accept),
      .adv   (adv_vec[g]),
      .op    (op_q[g]),
      .wrap  (wrap_vec[g]),
      .s_bit (s_vec[g])
    );
  end

  assign cyc_next = cyc_q + 1'b1;
  assign c_ext    = {{(LEN_WIDTH-CYC_WIDTH){1'b0}}, cyc_next};
  assign lim_ext  = {{(LEN_WIDTH-CYC_WIDTH){1'b0}}, limit_q};
  assign l_len    = exact_len(32'(op_q[NUM_INPUTS-1]), 32'(DATA_WIDTH * (NUM_INPUTS - 1)));

  // The slowest stream wrapping marks exactly F cycles: the full-length exit.
  assign finish = wrap_vec[NUM_INPUTS-1]
               || ((limit_q != '0) && (c_ext == lim_ext))
               || (exact_q && (c_ext == l_len));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = zero_fast ? ST_DONE : ST_RUN;
      ST_RUN:  if (running && finish) state_d = ST_DONE;
      ST_DONE: begin
        if (accept)  state_d = zero_fast ? ST_DONE : ST_RUN;
        else if (en) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      limit_q <= '0;
      exact_q <= 1'b0;
      ones_q  <= '0;
      cyc_q   <= '0;
      trunc_q <= 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++) op_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
          op_q[i] <= bin_data_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
        limit_q <= cycle_limit;
        exact_q <= exact_exit_en;
        ones_q  <= '0;
        cyc_q   <= '0;
        trunc_q <= 1'b0;
      end else if (running) begin
        ones_q <= ones_q + {{(OUT_W-1){1'b0}}, &s_vec};
        cyc_q  <= cyc_next;
        if (finish) trunc_q <= (c_ext < l_len);
      end
    end
  end

  assign op_finished  = (state_q == ST_DONE);
  assign bin_data_out = ones_q;
  assign cycle_count  = cyc_q;
  assign truncated    = trunc_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_dsc_mul_engine.sv
// Self-checking bench for dsc_mul_engine: directed and random runs checked
// against a digit-counting reference model of the unary multiplier.
module tb_dsc_mul_engine;
  import dsc_pkg::*;

  localparam int DW = DEF_DATA_WIDTH;
  localparam int NI = DEF_NUM_INPUTS;
  localparam int OW = OUT_WIDTH;
  localparam int CW = OW + 1;
  localparam int EW = 1 + CW + OW;

  logic             gclk = 1'b0;
  logic             rst;
  logic             en;
  logic             start;
  logic [OW-1:0]    bin_data_in;
  logic [CW-1:0]    cycle_limit;
  logic             exact_exit_en;
  logic             ready;
  logic             op_finished;
  logic [OW-1:0]    bin_data_out;
  logic [CW-1:0]    cycle_count;
  logic             truncated;
  dsc_state_e       dbg_state;

  logic [EW-1:0]    exp_q[$];
  int               n_checks = 0;
  int               n_errors = 0;

  // Clock / reset
  always #5 gclk = ~gclk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  dsc_mul_engine #(.DATA_WIDTH(DW), .NUM_INPUTS(NI), .CYC_WIDTH(CW)) dut (
    .gclk          (gclk),
    .rst           (rst),
    .en            (en),
    .start         (start),
    .bin_data_in   (bin_data_in),
    .cycle_limit   (cycle_limit),
    .exact_exit_en (exact_exit_en),
    .ready         (ready),
    .op_finished   (op_finished),
    .bin_data_out  (bin_data_out),
    .cycle_count   (cycle_count),
    .truncated     (truncated),
    .dbg_state     (dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: run length from the exit rules, then count stream instants t
  // where every base-2^DW digit of t lies below its operand.
  function automatic void model(input int ops[NI], input int limit, input bit exact,
                                output int ones, output int len, output bit trunc);
    int  full;
    int  l;
    bit  anyz;
    full = 1 << OW;
    l    = ops[NI-1] << (DW * (NI - 1));
    anyz = 1'b0;
    for (int i = 0; i < NI; i++) if (ops[i] == 0) anyz = 1'b1;
    if (exact && anyz) begin
      ones = 0; len = 0; trunc = 1'b0;
      return;
    end
    len = full;
    if (limit != 0 && limit < len) len = limit;
    if (exact && l < len) len = l;
    ones = 0;
    for (int t = 0; t < len; t++) begin
      bit hit;
      hit = 1'b1;
      for (int i = 0; i < NI; i++) begin
        if (((t >> (DW * i)) % (1 << DW)) >= ops[i]) hit = 1'b0;
      end
      if (hit) ones++;
    end
    trunc = (len < l);
  endfunction

  // Driver: one request, optional stall window and stray start during RUN.
  task automatic run_op(input int op0, input int op1, input int limit, input bit exact,
                        input int stall_at, input int stall_len, input int start_at,
                        input bit b2b);
    int            ops[NI];
    int            e_ones;
    int            e_len;
    bit            e_tr;
    int            wait_n;
    logic [EW-1:0] e;
    ops[0] = op0;
    ops[1] = op1;
    model(ops, limit, exact, e_ones, e_len, e_tr);
    exp_q.push_back({e_tr, CW'(e_len), OW'(e_ones)});
    check("ready_before", 64'(ready), 64'd1);
    bin_data_in   = {op1[DW-1:0], op0[DW-1:0]};
    cycle_limit   = CW'(limit);
    exact_exit_en = exact;
    start         = 1'b1;
    @(negedge gclk);
    start = 1'b0;
    check("cleared_count", 64'(cycle_count), 64'd0);
    wait_n = 0;
    while (!op_finished && wait_n < e_len + stall_len + 20) begin
      if (wait_n == stall_at) en = 1'b0;
      if (wait_n == stall_at + stall_len) en = 1'b1;
      start = (wait_n == start_at);
      if (wait_n == start_at) bin_data_in = OW'($urandom);
      @(negedge gclk);
      wait_n++;
    end
    en    = 1'b1;
    start = 1'b0;
    check("op_finished", 64'(op_finished), 64'd1);
    e = exp_q.pop_front();
    check("latency", 64'(wait_n), 64'(e_len + stall_len));
    check("ones", 64'(bin_data_out), 64'(e[OW-1:0]));
    check("cycle_count", 64'(cycle_count), 64'(e[OW+CW-1:OW]));
    check("truncated", 64'(truncated), 64'(e[EW-1]));
    check("ready_done", 64'(ready), 64'd1);
    if (!b2b) begin
      @(negedge gclk);
      check("pulse_end", 64'(op_finished), 64'd0);
      check("hold_ones", 64'(bin_data_out), 64'(e[OW-1:0]));
    end
  endtask

  initial begin
    rst           = 1'b1;
    en            = 1'b1;
    start         = 1'b0;
    bin_data_in   = '0;
    cycle_limit   = '0;
    exact_exit_en = 1'b0;
    repeat (3) @(negedge gclk);
    rst = 1'b0;
    @(negedge gclk);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_finished", 64'(op_finished), 64'd0);
    check("rst_out", 64'(bin_data_out), 64'd0);
    check("rst_count", 64'(cycle_count), 64'd0);
    check("rst_trunc", 64'(truncated), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));

    run_op(3, 5, 0, 1'b0, -1, 0, -1, 1'b0);       // full run
    run_op(3, 5, 0, 1'b1, -1, 0, -1, 1'b0);       // exact exit at 1280
    run_op(255, 255, 1000, 1'b1, -1, 0, -1, 1'b1); // budget-truncated, stays in DONE

    // Stalled in DONE: op_finished and results hold
    en = 1'b0;
    repeat (5) @(negedge gclk);
    check("stall_done_fin", 64'(op_finished), 64'd1);
    check("stall_done_state", 64'(dbg_state), 64'(ST_DONE));
    check("stall_done_count", 64'(cycle_count), 64'd1000);
    en = 1'b1;
    @(negedge gclk);
    check("stall_done_exit", 64'(op_finished), 64'd0);

    run_op(0, 200, 0, 1'b1, -1, 0, -1, 1'b0);     // zero fast path
    run_op(0, 200, 3000, 1'b0, -1, 0, -1, 1'b0);  // zero operand runs normally
    run_op(3, 5, 0, 1'b1, 300, 10, 600, 1'b0);    // 10-cycle stall + stray start
    run_op(200, 3, 900, 1'b1, -1, 0, -1, 1'b1);   // back-to-back chain from DONE
    run_op(0, 9, 0, 1'b1, -1, 0, -1, 1'b1);
    run_op(7, 1, 0, 1'b1, -1, 0, -1, 1'b0);

    // Reset mid-run aborts immediately
    bin_data_in   = {8'd5, 8'd3};
    cycle_limit   = '0;
    exact_exit_en = 1'b1;
    start         = 1'b1;
    @(negedge gclk);
    start = 1'b0;
    repeat (100) @(negedge gclk);
    check("mid_count", 64'(cycle_count), 64'd100);
    check("mid_state", 64'(dbg_state), 64'(ST_RUN));
    rst = 1'b1;
    #1;
    check("abort_ready", 64'(ready), 64'd1);
    check("abort_out", 64'(bin_data_out), 64'd0);
    check("abort_count", 64'(cycle_count), 64'd0);
    check("abort_trunc", 64'(truncated), 64'd0);
    check("abort_fin", 64'(op_finished), 64'd0);
    @(negedge gclk);
    rst = 1'b0;
    repeat (3) @(negedge gclk);
    check("abort_no_fin", 64'(op_finished), 64'd0);
    run_op(7, 9, 0, 1'b1, -1, 0, -1, 1'b0);

    // Random operands, budgets and modes
    for (int k = 0; k < 8; k++) begin
      int a;
      int b;
      a = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
      run_op(a, b, int'($urandom_range(1, 800)), 1'($urandom_range(0, 1)), -1, 0, -1,
             (k == 7) ? 1'b0 : 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
